uart_text_buffer: RTL
=====================

Name: uart_text_buffer

Overview:
- Character-terminal back end between the UART receiver and the LCD1602 controller.
- Takes received bytes and maintains a NUM_LINES x CHARS_PER_LINE text frame with a cursor and control-character handling (CR, LF, BS, FF).
- Exposes a synchronous read port so the LCD controller can scan the frame.
- Keeps an internal first-word-fall-through echo FIFO toward the UART transmitter, with a valid/ready handshake and overflow reporting.

Parameters:
- DATA_BITS, 8: character width.
- NUM_LINES, 2: display lines.
- CHARS_PER_LINE, 16: characters per line.
- ECHO_FIFO_EXP, 4: echo FIFO depth = 2**ECHO_FIFO_EXP.
- FILL_CHAR, 8'h20: value written by clear operations.
- Derived: DEPTH = NUM_LINES*CHARS_PER_LINE; AW = $clog2(DEPTH); LW = max(1,$clog2(NUM_LINES)); CW = $clog2(CHARS_PER_LINE).

Ports:
- clk_50MHz  in  1  system clock
- reset  in  1  synchronous reset, active-high
- rx_valid  in  1  one-cycle pulse, byte received
- rx_data  in  DATA_BITS  received byte, valid with rx_valid
- disp_addr  in  AW  frame read address (line*CHARS_PER_LINE+col)
- disp_data  out  DATA_BITS  frame contents at disp_addr, 1-cycle latency
- frame_update  out  1  one-cycle pulse after any frame content change completes
- busy  out  1  clear operation in progress
- cursor_line  out  LW  current cursor line
- cursor_col  out  CW  current cursor column
- echo_valid  out  1  echo FIFO non-empty
- echo_data  out  DATA_BITS  echo FIFO head (FWFT)
- echo_ready  in  1  consumer accepts head when echo_valid
- echo_overflow  out  1  sticky: an echo byte was dropped
- drop_count  out  8  saturating count of bytes lost to the frame path

Behaviour:
- Reset (synchronous, active-high, all on the next clk_50MHz edge):
  - cursor = 0,0; echo FIFO empty; echo_overflow = 0; drop_count = 0; frame_update = 0; pending slot empty.
  - FSM enters CLEAR_ALL, so busy = 1.
  - Reset asserted mid-operation aborts it and restarts CLEAR_ALL.
- FSM states: CLEAR_ALL, IDLE, CLEAR_LINE.
  - CLEAR_ALL writes FILL_CHAR to addresses 0..DEPTH-1, one per cycle (DEPTH cycles), then pulses frame_update and goes to IDLE.
  - CLEAR_LINE writes FILL_CHAR to the CHARS_PER_LINE entries of cursor_line, then pulses frame_update and goes to IDLE.
  - busy = 1 in both clear states.
- Byte decode in IDLE. The byte comes from the pending slot if full, else from rx_valid/rx_data.
  - Printable 0x20-0x7E:
    - Write at cursor on the next edge; col+1.
    - At col = CHARS_PER_LINE-1: col = 0 and line+1, wrapping from NUM_LINES-1 to 0. No scroll.
    - frame_update pulses the cycle after the write.
  - 0x0D (CR): col = 0; no write; no frame_update.
  - 0x0A (LF): line = (line+1) mod NUM_LINES; col = 0; go to CLEAR_LINE on the new line.
  - 0x08 (BS):
    - col > 0: col-1, write FILL_CHAR there, frame_update.
    - col = 0: no-op.
  - 0x0C (FF): cursor = 0,0; go to CLEAR_ALL.
  - Any other byte: ignored by the frame path (still echoed).
- Bytes arriving while busy:
  - Held in a 1-deep pending slot; processed on the first IDLE cycle.
  - A byte arriving while the slot is full is dropped from the frame path; drop_count+1, saturating at 255.
  - In IDLE with the slot full, a new rx byte goes into the slot after the slot drains; IDLE consumes the slot first.
- Read port:
  - disp_data is registered from disp_addr with 1-cycle latency.
  - A read and write to the same address in the same cycle returns the old value.
  - disp_addr >= DEPTH returns FILL_CHAR.
- Echo FIFO:
  - Every rx_valid pushes rx_data regardless of FSM state.
  - Pop occurs when echo_valid && echo_ready.
  - Push into an empty FIFO: echo_valid = 1 on the following cycle, with echo_data = that byte.
  - Full, no pop: the byte is dropped and echo_overflow = 1 (cleared only by reset).
  - Full with simultaneous pop: the push is accepted and the count is unchanged.
  - Pointers wrap modulo 2**ECHO_FIFO_EXP.

Test Plan:
1. Reset, then wait DEPTH cycles, then read addresses 0..31 -> busy = 1 for exactly 32 cycles; all reads = 8'h20; cursor 0,0.
2. Send "HELLO" then 0x0D then "J" -> frame[0..4] = "JELLO" (J overwrites H); cursor 0,1; frame_update pulses 6 times.
3. Send 17 x 'A' -> frame[0..16] = 'A'; cursor 1,1. Then send 0x0A -> busy = 1 for 16 cycles, line 0 cleared to 8'h20, cursor 0,0, line 1 intact.
4. Send 0x0C immediately followed by 'X','Y' one cycle apart while busy -> 'X' held and written at 0,0 after the clear; 'Y' dropped; drop_count = 1; echo receives 0x0C,'X','Y' in order.
5. Hold echo_ready = 0 and send 17 bytes with ECHO_FIFO_EXP = 4 -> 16 bytes retained, echo_overflow = 1. Then echo_ready = 1 -> exactly 16 bytes pop in arrival order; echo_valid = 0 afterwards.
6. Send BS at col 0, then 'Q', BS -> first BS is a no-op; final cursor 0,0 and frame[0] = 8'h20. Assert reset mid-CLEAR_LINE -> CLEAR_ALL restarts; drop_count = 0.

Source files
------------

// File: rtl/uart_text_buffer_if.sv
// Bundles the UART-side, display-side and echo-side signals of uart_text_buffer.
// Latency: none; wires only.
// Backpressure: echo side is valid/ready; rx side is a one-cycle pulse with no backpressure.
// Ports (slave = text buffer view):
//   rx_valid/rx_data        in   received byte pulse
//   disp_addr / disp_data   in / out  frame read port, 1-cycle latency
//   frame_update, busy      out  frame change pulse, clear in progress
//   cursor_line/cursor_col  out  current cursor position
//   echo_valid/echo_data    out  FWFT echo FIFO head
//   echo_ready              in   echo consumer accept
//   echo_overflow           out  sticky echo drop flag
//   drop_count              out  saturating count of frame-path drops
interface uart_text_buffer_if #(
  parameter int DATA_BITS = 8,
  parameter int AW        = 5,
  parameter int LW        = 1,
  parameter int CW        = 4
);
  logic                 rx_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic [AW-1:0]        disp_addr;
  logic [DATA_BITS-1:0] disp_data;
  logic                 frame_update;
  logic                 busy;
  logic [LW-1:0]        cursor_line;
  logic [CW-1:0]        cursor_col;
  logic                 echo_valid;
  logic [DATA_BITS-1:0] echo_data;
  logic                 echo_ready;
  logic                 echo_overflow;
  logic [7:0]           drop_count;

  modport slave (
    input  rx_valid, rx_data, disp_addr, echo_ready,
    output disp_data, frame_update, busy, cursor_line, cursor_col,
           echo_valid, echo_data, echo_overflow, drop_count
  );

  modport master (
    output rx_valid, rx_data, disp_addr, echo_ready,
    input  disp_data, frame_update, busy, cursor_line, cursor_col,
           echo_valid, echo_data, echo_overflow, drop_count
  );
endinterface

// File: rtl/uart_text_buffer.sv
// Character-terminal frame buffer (CR/LF/BS/FF) between UART RX and an LCD scanner, plus echo FIFO.
// Latency: frame write on the edge after the byte; disp_data 1 cycle; echo_valid 1 cycle after push.
// Backpressure: rx cannot be stalled; 1-deep pending slot while clearing, extra bytes counted in drop_count;
//   echo FIFO drops on full (sticky echo_overflow) unless a pop happens in the same cycle.
// Ports: clk_50MHz, reset (sync, active-high), bus (uart_text_buffer_if.slave, see interface header).
module uart_text_buffer #(
  parameter int              DATA_BITS      = 8,
  parameter int              NUM_LINES      = 2,
  parameter int              CHARS_PER_LINE = 16,
  parameter int              ECHO_FIFO_EXP  = 4,
  parameter logic [DATA_BITS-1:0] FILL_CHAR = 8'h20
) (
  input  logic               clk_50MHz,
  input  logic               reset,
  uart_text_buffer_if.slave  bus
);
  localparam int DEPTH = NUM_LINES * CHARS_PER_LINE;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int CW    = (CHARS_PER_LINE > 1) ? $clog2(CHARS_PER_LINE) : 1;
  localparam int FD    = 2 ** ECHO_FIFO_EXP;
  localparam int CNTW  = ECHO_FIFO_EXP + 1;

  localparam logic [1:0] ST_CLEAR_ALL  = 2'd0;
  localparam logic [1:0] ST_IDLE       = 2'd1;
  localparam logic [1:0] ST_CLEAR_LINE = 2'd2;

  localparam logic [DATA_BITS-1:0] CH_BS = DATA_BITS'(8'h08);
  localparam logic [DATA_BITS-1:0] CH_LF = DATA_BITS'(8'h0A);
  localparam logic [DATA_BITS-1:0] CH_FF = DATA_BITS'(8'h0C);
  localparam logic [DATA_BITS-1:0] CH_CR = DATA_BITS'(8'h0D);
  localparam logic [DATA_BITS-1:0] CH_LO = DATA_BITS'(8'h20);
  localparam logic [DATA_BITS-1:0] CH_HI = DATA_BITS'(8'h7E);

  // ---------------- frame control state ----------------
  logic [1:0]           state_q, state_d;
  logic [AW-1:0]        clr_cnt_q, clr_cnt_d;
  logic [LW-1:0]        line_q, line_d;
  logic [CW-1:0]        col_q, col_d;
  logic                 pend_full_q, pend_full_d;
  logic [DATA_BITS-1:0] pend_dat_q, pend_dat_d;
  logic [7:0]           drop_q, drop_d;
  logic                 upd_q, upd_d;

  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [DATA_BITS-1:0] wr_dat;

  logic [DATA_BITS-1:0] frame_mem [DEPTH];
  logic [DATA_BITS-1:0] disp_q;

  logic [DATA_BITS-1:0] cur_byte;
  logic                 have_byte;
  logic [AW-1:0]        line_base;
  logic [AW-1:0]        cur_addr;
  logic [LW-1:0]        line_next;

  // The pending slot always has priority over a fresh rx byte in IDLE.
  assign cur_byte  = pend_full_q ? pend_dat_q : bus.rx_data;
  assign have_byte = pend_full_q | bus.rx_valid;
  assign line_base = AW'(line_q) * AW'(CHARS_PER_LINE);
  assign cur_addr  = line_base + AW'(col_q);
  assign line_next = (line_q == LW'(NUM_LINES - 1)) ? '0 : line_q + LW'(1);

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    line_d      = line_q;
    col_d       = col_q;
    pend_full_d = pend_full_q;
    pend_dat_d  = pend_dat_q;
    drop_d      = drop_q;
    upd_d       = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_dat      = FILL_CHAR;

    case (state_q)
      ST_CLEAR_ALL: begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt_q;
        if (clr_cnt_q == AW'(DEPTH - 1)) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
          upd_d     = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end

      ST_CLEAR_LINE: begin
        // line_q already points at the line being cleared
        wr_en   = 1'b1;
        wr_addr = line_base + clr_cnt_q;
        if (clr_cnt_q == AW'(CHARS_PER_LINE - 1)) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
          upd_d     = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end

      ST_IDLE: begin
        if (have_byte) begin
          if (cur_byte >= CH_LO && cur_byte <= CH_HI) begin
            wr_en   = 1'b1;
            wr_addr = cur_addr;
            wr_dat  = cur_byte;
            upd_d   = 1'b1;
            if (col_q == CW'(CHARS_PER_LINE - 1)) begin
              col_d  = '0;
              line_d = line_next;
            end else begin
              col_d = col_q + CW'(1);
            end
          end else if (cur_byte == CH_CR) begin
            col_d = '0;
          end else if (cur_byte == CH_LF) begin
            line_d    = line_next;
            col_d     = '0;
            clr_cnt_d = '0;
            state_d   = ST_CLEAR_LINE;
          end else if (cur_byte == CH_BS) begin
            if (col_q != '0) begin
              col_d   = col_q - CW'(1);
              wr_en   = 1'b1;
              wr_addr = cur_addr - AW'(1);
              upd_d   = 1'b1;
            end
          end else if (cur_byte == CH_FF) begin
            line_d    = '0;
            col_d     = '0;
            clr_cnt_d = '0;
            state_d   = ST_CLEAR_ALL;
          end
        end
      end

      default: begin
        state_d   = ST_CLEAR_ALL;
        clr_cnt_d = '0;
      end
    endcase

    // Pending slot: fills while clearing; in IDLE a full slot is consumed
    // above and refilled by any rx byte arriving in the same cycle.
    if (state_q != ST_IDLE) begin
      if (bus.rx_valid) begin
        if (!pend_full_q) begin
          pend_full_d = 1'b1;
          pend_dat_d  = bus.rx_data;
        end else if (drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
      end
    end else if (pend_full_q) begin
      pend_full_d = bus.rx_valid;
      if (bus.rx_valid) begin
        pend_dat_d = bus.rx_data;
      end
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q     <= ST_CLEAR_ALL;
      clr_cnt_q   <= '0;
      line_q      <= '0;
      col_q       <= '0;
      pend_full_q <= 1'b0;
      pend_dat_q  <= '0;
      drop_q      <= '0;
      upd_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      line_q      <= line_d;
      col_q       <= col_d;
      pend_full_q <= pend_full_d;
      pend_dat_q  <= pend_dat_d;
      drop_q      <= drop_d;
      upd_q       <= upd_d;
    end
  end

  // Frame RAM: registered read sees the pre-write value on a same-address collision.
  always_ff @(posedge clk_50MHz) begin
    if (wr_en && !reset) begin
      frame_mem[wr_addr] <= wr_dat;
    end
    if ({1'b0, bus.disp_addr} < (AW + 1)'(DEPTH)) begin
      disp_q <= frame_mem[bus.disp_addr];
    end else begin
      disp_q <= FILL_CHAR;
    end
  end

  // ---------------- echo FIFO ----------------
  logic [DATA_BITS-1:0]     fifo_mem [FD];
  logic [ECHO_FIFO_EXP-1:0] wr_ptr_q, wr_ptr_d;
  logic [ECHO_FIFO_EXP-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic                     echo_full;
  logic                     echo_pop;
  logic                     echo_push;

  assign echo_full = (cnt_q == CNTW'(FD));
  assign echo_pop  = (cnt_q != '0) && bus.echo_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign echo_push = bus.rx_valid && (!echo_full || echo_pop);

  always_comb begin
    wr_ptr_d = echo_push ? wr_ptr_q + ECHO_FIFO_EXP'(1) : wr_ptr_q;
    rd_ptr_d = echo_pop  ? rd_ptr_q + ECHO_FIFO_EXP'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (echo_push && !echo_pop) begin
      cnt_d = cnt_q + CNTW'(1);
    end else if (!echo_push && echo_pop) begin
      cnt_d = cnt_q - CNTW'(1);
    end
    ovf_d = ovf_q | (bus.rx_valid && !echo_push);
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (echo_push && !reset) begin
      fifo_mem[wr_ptr_q] <= bus.rx_data;
    end
  end

  // ---------------- outputs ----------------
  assign bus.disp_data     = disp_q;
  assign bus.frame_update  = upd_q;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.cursor_line   = line_q;
  assign bus.cursor_col    = col_q;
  assign bus.echo_valid    = (cnt_q != '0);
  assign bus.echo_data     = fifo_mem[rd_ptr_q];
  assign bus.echo_overflow = ovf_q;
  assign bus.drop_count    = drop_q;
endmodule
